mac_rx_ingest: RTL and testbench

Receive-side ingest stage between the MAC's Avalon-ST receive port and the sniffer controller. It buffers each packet in an internal store-and-forward FIFO and publishes only complete, error-free packets to the read side. Errored, truncated and oversize packets are rewound and discarded, so the controller's compare pass never sees a partial frame. It also keeps packet and drop statistics for the Avalon slave.

---
 rtl/eth_sniffer_pkg.sv | 14 +
 rtl/ingest_ram.sv | 45 ++++
 rtl/mac_rx_ingest.sv | 139 +++++++++++++
 tb/tb_mac_rx_ingest.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/eth_sniffer_pkg.sv
// Shared types for the sniffer receive path.
//   ingest_state_t : ingest FSM states (idle, receiving a packet, discarding the rest of a packet)
//   COUNT_W        : width of the statistics counters
package eth_sniffer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DISCARD = 2'd2
    } ingest_state_t;

    localparam int COUNT_W = 32;

endpackage

// File: rtl/ingest_ram.sv
// Simple dual-port RAM backing the ingest store-and-forward FIFO.
// Word layout is {empty, eop, data}. The read port is registered and drives
// the q_* outputs directly; the read register clears on reset.
//   clk, rst     : clock, synchronous active-high reset (read register only)
//   we/waddr/... : write port, written on the clock edge when we is high
//   re/raddr     : read port; the addressed word appears on q_* one cycle later
//   q_*          : registered read word, holds when re is low
module ingest_ram #(
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2,
    parameter int DEPTH   = 64,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int WORD_W = DATA_W + 1 + EMPTY_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] q_data,
    output logic              q_eop,
    output logic [EMPTY_W-1:0] q_empty
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] q_word;

    // Storage array is left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            q_word <= '0;
        else if (re)
            q_word <= mem[raddr];
    end

    assign {q_empty, q_eop, q_data} = q_word;

endmodule

// File: rtl/mac_rx_ingest.sv
// Receive ingest stage: buffers MAC packets in a store-and-forward FIFO and
// only publishes complete, error-free packets to the controller.
//   clk, rst            : clock, synchronous active-high reset
//   st_*                : Avalon-ST receive from the MAC; st_ready never back-pressures
//   rdreq, rdempty, q_* : read side; q_* valid the cycle after an accepted rdreq
//   pkt_done, pkt_drop  : one-cycle pulses for a committed / discarded packet
//   pkt_count, drop_count : wrapping statistics counters
module mac_rx_ingest
    import eth_sniffer_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2,
    parameter int DEPTH   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  st_data,
    input  logic               st_valid,
    input  logic               st_sop,
    input  logic               st_eop,
    input  logic               st_error,
    input  logic [EMPTY_W-1:0] st_empty,
    output logic               st_ready,
    input  logic               rdreq,
    output logic               rdempty,
    output logic [DATA_W-1:0]  q_data,
    output logic               q_eop,
    output logic [EMPTY_W-1:0] q_empty,
    output logic               pkt_done,
    output logic               pkt_drop,
    output logic [COUNT_W-1:0] pkt_count,
    output logic [COUNT_W-1:0] drop_count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PW     = ADDR_W + 1;

    ingest_state_t state, state_n;

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
    logic [PW-1:0] wr_n, commit_n, base, fill;
    logic          accept, full, re, we;
    logic          do_commit, do_drop;

    assign accept  = st_valid & st_ready;
    assign fill    = wr_ptr - rd_ptr;
    assign full    = (fill == PW'(DEPTH));   // pre-read rd_ptr: conservative
    assign rdempty = (rd_ptr == commit_ptr);
    assign re      = rdreq & ~rdempty;

    // A sop beat always starts at the last commit point, which also rewinds
    // any unfinished packet in flight.
    assign base = st_sop ? commit_ptr : wr_ptr;

    always_comb begin
        state_n   = state;
        wr_n      = wr_ptr;
        commit_n  = commit_ptr;
        we        = 1'b0;
        do_commit = 1'b0;
        do_drop   = 1'b0;
        if (accept) begin
            case (state)
                IDLE, RECV: begin
                    // In IDLE only a sop beat opens a packet; stray beats are ignored.
                    if (state == RECV || st_sop) begin
                        if (full || st_error) begin
                            do_drop = 1'b1;
                            wr_n    = commit_ptr;
                            state_n = st_eop ? IDLE : DISCARD;
                        end else begin
                            do_drop = (state == RECV) && st_sop;
                            we      = 1'b1;
                            wr_n    = base + PW'(1);
                            if (st_eop) begin
                                commit_n  = base + PW'(1);
                                do_commit = 1'b1;
                                state_n   = IDLE;
                            end else begin
                                state_n   = RECV;
                            end
                        end
                    end
                end
                DISCARD: begin
                    if (st_eop)
                        state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            st_ready   <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_drop   <= 1'b0;
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            state      <= state_n;
            wr_ptr     <= wr_n;
            commit_ptr <= commit_n;
            if (re)
                rd_ptr <= rd_ptr + PW'(1);
            st_ready   <= 1'b1;
            pkt_done   <= do_commit;
            pkt_drop   <= do_drop;
            if (do_commit)
                pkt_count  <= pkt_count + COUNT_W'(1);
            if (do_drop)
                drop_count <= drop_count + COUNT_W'(1);
        end
    end

    ingest_ram #(
        .DATA_W  (DATA_W),
        .EMPTY_W (EMPTY_W),
        .DEPTH   (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (base[ADDR_W-1:0]),
        .wdata   ({st_empty, st_eop, st_data}),
        .re      (re),
        .raddr   (rd_ptr[ADDR_W-1:0]),
        .q_data  (q_data),
        .q_eop   (q_eop),
        .q_empty (q_empty)
    );

endmodule

// File: tb/tb_mac_rx_ingest.sv
// Randomized bench for mac_rx_ingest. A packet-level reference model keeps
// the committed words in a queue and the packet being received in another;
// FIFO occupancy is simply the sum of the two queue sizes.
module tb_mac_rx_ingest;

    localparam int DATA_W  = 32;
    localparam int EMPTY_W = 2;
    localparam int DEPTH   = 64;

    typedef logic [DATA_W+EMPTY_W:0] word_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [DATA_W-1:0]  st_data = '0;
    logic               st_valid = 1'b0;
    logic               st_sop = 1'b0;
    logic               st_eop = 1'b0;
    logic               st_error = 1'b0;
    logic [EMPTY_W-1:0] st_empty = '0;
    logic               st_ready;
    logic               rdreq = 1'b0;
    logic               rdempty;
    logic [DATA_W-1:0]  q_data;
    logic               q_eop;
    logic [EMPTY_W-1:0] q_empty;
    logic               pkt_done, pkt_drop;
    logic [31:0]        pkt_count, drop_count;

    mac_rx_ingest #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop),
        .st_error(st_error), .st_empty(st_empty), .st_ready(st_ready),
        .rdreq(rdreq), .rdempty(rdempty),
        .q_data(q_data), .q_eop(q_eop), .q_empty(q_empty),
        .pkt_done(pkt_done), .pkt_drop(pkt_drop),
        .pkt_count(pkt_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: mode 0 = between packets, 1 = in a packet, 2 = dropping rest of packet
    word_t       cq[$];
    word_t       cur[$];
    int          mode = 0;
    word_t       m_q = '0;
    bit          m_done = 0, m_drop = 0, m_ready = 0;
    logic [31:0] m_pcnt = '0, m_dcnt = '0;

    task automatic step(input bit r, input bit v, input bit sop, input bit eop, input bit err,
                        input logic [DATA_W-1:0] d, input logic [EMPTY_W-1:0] e, input bit rd);
        bit    rd_ok, acc, full;
        word_t w;
        rst = r; st_valid = v; st_sop = sop; st_eop = eop; st_error = err;
        st_data = d; st_empty = e; rdreq = rd;
        @(posedge clk);
        if (r) begin
            cq.delete(); cur.delete(); mode = 0; m_q = '0;
            m_done = 0; m_drop = 0; m_ready = 0; m_pcnt = '0; m_dcnt = '0;
        end else begin
            rd_ok  = rd && (cq.size() > 0);
            acc    = v && m_ready;
            m_done = 0;
            m_drop = 0;
            w      = {e, eop, d};
            if (acc) begin
                if (mode == 2) begin
                    if (eop) mode = 0;
                end else if (mode == 1 || sop) begin
                    full = (cq.size() + cur.size()) == DEPTH;
                    if (full || err) begin
                        m_drop = 1; cur.delete(); mode = eop ? 0 : 2;
                    end else begin
                        if (mode == 1 && sop) begin m_drop = 1; cur.delete(); end
                        cur.push_back(w);
                        if (eop) begin
                            foreach (cur[i]) cq.push_back(cur[i]);
                            cur.delete(); m_done = 1; mode = 0;
                        end else begin
                            mode = 1;
                        end
                    end
                end
            end
            if (rd_ok) m_q = cq.pop_front();
            if (m_done) m_pcnt = m_pcnt + 1;
            if (m_drop) m_dcnt = m_dcnt + 1;
            m_ready = 1;
        end
        #1;
        chk("st_ready",   64'(st_ready),   64'(m_ready));
        chk("rdempty",    64'(rdempty),    64'(cq.size() == 0));
        chk("q_word",     64'({q_empty, q_eop, q_data}), 64'(m_q));
        chk("pkt_done",   64'(pkt_done),   64'(m_done));
        chk("pkt_drop",   64'(pkt_drop),   64'(m_drop));
        chk("pkt_count",  64'(pkt_count),  64'(m_pcnt));
        chk("drop_count", 64'(drop_count), 64'(m_dcnt));
    endtask

    task automatic idle(input int n, input bit rd);
        repeat (n) step(0, 0, 0, 0, 0, '0, '0, rd);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, '0, '0, 0);
        idle(1, 0);
    endtask

    // rdmode: 0 no reads, 1 read every cycle, 2 random reads
    task automatic send_pkt(input int len, input int err_at, input bit noeop,
                            input int rdmode, input bit gaps);
        bit rdb;
        for (int i = 0; i < len; i++) begin
            rdb = (rdmode == 1) ? 1'b1 : (rdmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (gaps && $urandom_range(0, 3) == 0) idle(1, rdb);
            step(0, 1, i == 0, (i == len - 1) && !noeop, i == err_at, $urandom,
                 (i == len - 1) ? EMPTY_W'($urandom_range(0, 3)) : '0, rdb);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (cq.size() > 0 && guard < DEPTH * 4) begin
            step(0, 0, 0, 0, 0, '0, '0, 1);
            guard++;
        end
        chk("drain_bound", 64'(guard < DEPTH * 4), 64'd1);
        idle(1, 0);
    endtask

    initial begin
        // Reset state
        do_reset();

        // One-beat packet with fixed contents
        step(0, 1, 1, 1, 0, 32'hDEADBEEF, 2'd2, 0);
        chk("t1_done",  64'(pkt_done), 64'd1);
        chk("t1_count", 64'(pkt_count), 64'd1);
        step(0, 0, 0, 0, 0, '0, '0, 1);
        chk("t1_q_data",  64'(q_data), 64'hDEADBEEF);
        chk("t1_q_eop",   64'(q_eop), 64'd1);
        chk("t1_q_empty", 64'(q_empty), 64'd2);
        chk("t1_rdempty", 64'(rdempty), 64'd1);

        // Error on beat 5 of a 10-beat packet, then a good 3-beat packet
        do_reset();
        send_pkt(10, 4, 0, 0, 0);
        idle(1, 0);
        chk("t2_drops",   64'(drop_count), 64'd1);
        chk("t2_rdempty", 64'(rdempty), 64'd1);
        send_pkt(3, -1, 0, 0, 0);
        drain();
        chk("t2_pkts", 64'(pkt_count), 64'd1);

        // Oversize packet, then a 4-beat packet
        do_reset();
        send_pkt(70, -1, 0, 0, 0);
        idle(1, 0);
        chk("t3_drops",   64'(drop_count), 64'd1);
        chk("t3_rdempty", 64'(rdempty), 64'd1);
        send_pkt(4, -1, 0, 0, 0);
        drain();
        chk("t3_pkts", 64'(pkt_count), 64'd1);

        // sop at beat 4 of an unfinished packet
        do_reset();
        send_pkt(3, -1, 1, 0, 0);
        send_pkt(3, -1, 0, 0, 0);
        idle(1, 0);
        chk("t4_drops", 64'(drop_count), 64'd1);
        chk("t4_pkts",  64'(pkt_count), 64'd1);
        drain();

        // 200 back-to-back 8-beat packets with reads held high
        do_reset();
        for (int p = 0; p < 200; p++) send_pkt(8, -1, 0, 1, 0);
        drain();
        chk("t5_pkts",  64'(pkt_count), 64'd200);
        chk("t5_drops", 64'(drop_count), 64'd0);

        // Random mix
        do_reset();
        for (int p = 0; p < 300; p++) begin
            int len, err_at;
            len    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(50, 80)) : int'($urandom_range(1, 12));
            err_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            if ($urandom_range(0, 9) == 0)
                step(0, 1, 0, 1'($urandom_range(0, 1)), 0, $urandom, '0, 0);
            send_pkt(len, err_at, $urandom_range(0, 9) == 0, int'($urandom_range(0, 2)), 1);
            if ($urandom_range(0, 19) == 0) drain();
        end
        drain();

        // Reset mid-packet with 20 committed beats unread
        do_reset();
        for (int p = 0; p < 4; p++) send_pkt(5, -1, 0, 0, 0);
        send_pkt(3, -1, 1, 0, 0);
        step(1, 0, 0, 0, 0, '0, '0, 0);
        chk("t7_rdempty", 64'(rdempty), 64'd1);
        chk("t7_pkts",    64'(pkt_count), 64'd0);
        chk("t7_ready0",  64'(st_ready), 64'd0);
        idle(1, 0);
        chk("t7_ready1",  64'(st_ready), 64'd1);
        send_pkt(2, -1, 0, 0, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
